// File: rtl/pipeline_result_stage_pkg.sv
// Shared definitions for the memory-to-writeback result stage.
// Holds the default widths and the named result-source encodings.
package pipeline_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_MEM = 2'd1,
        SRC_PC4 = 2'd2,
        SRC_IMM = 2'd3
    } result_src_e;

endpackage

// File: rtl/pipeline_result_stage_if.sv
// Bus between the memory-access stage, the hazard unit and the writeback stage.
// Valid/ready note: there is no ready; stall_i is the only back-pressure, and a slot is taken when valid_i=1 on a non-stalled, non-flushed edge.
interface pipeline_result_stage_if
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int NUM_SRC    = 4,
    parameter int ADDR_WIDTH = REG_ADDR_W
);
    localparam int SEL_WIDTH = $clog2(NUM_SRC);

    logic                          stall_i;
    logic                          flush_i;
    logic                          valid_i;
    logic [NUM_SRC*DATA_WIDTH-1:0] src_i;
    logic [SEL_WIDTH-1:0]          resultsrc_i;
    logic                          regwrite_i;
    logic [ADDR_WIDTH-1:0]         rd_i;
    logic [ADDR_WIDTH-1:0]         rs1_i;
    logic [ADDR_WIDTH-1:0]         rs2_i;
    logic                          valid_o;
    logic [DATA_WIDTH-1:0]         result_o;
    logic                          regwrite_o;
    logic [ADDR_WIDTH-1:0]         rd_o;
    logic                          fwd_hit1_o;
    logic                          fwd_hit2_o;
    logic                          sel_err_o;

    modport master (
        output stall_i, flush_i, valid_i, src_i, resultsrc_i, regwrite_i, rd_i, rs1_i, rs2_i,
        input  valid_o, result_o, regwrite_o, rd_o, fwd_hit1_o, fwd_hit2_o, sel_err_o
    );

    modport slave (
        input  stall_i, flush_i, valid_i, src_i, resultsrc_i, regwrite_i, rd_i, rs1_i, rs2_i,
        output valid_o, result_o, regwrite_o, rd_o, fwd_hit1_o, fwd_hit2_o, sel_err_o
    );

endinterface

// File: rtl/pipeline_result_stage_result_mux_n.sv
// Combinational N-way select of one packed result source.
// Out-of-range selects yield zero and raise sel_oob.
module result_mux_n
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int NUM_SRC    = 4,
    parameter int SEL_WIDTH  = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src,
    input  logic [SEL_WIDTH-1:0]          sel,
    output logic [DATA_WIDTH-1:0]         data,
    output logic                          sel_oob
);

    always_comb begin
        data    = '0;
        sel_oob = 1'b1;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (sel == SEL_WIDTH'(k)) begin
                data    = src[k*DATA_WIDTH +: DATA_WIDTH];
                sel_oob = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipeline_result_stage.sv
// M->W result stage: selects one result source and carries it, with rd/regwrite,
// through 1 or 2 identical registers; the last one feeds writeback and forwarding.
module pipeline_result_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int NUM_SRC    = 4,
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int OUT_REG    = 0
) (
    input logic                    clk,
    input logic                    rst,
    pipeline_result_stage_if.slave bus
);

    localparam int SEL_WIDTH  = $clog2(NUM_SRC);
    localparam int NUM_STAGES = 1 + OUT_REG;

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] result;
        logic                  regwrite;
        logic [ADDR_WIDTH-1:0] rd;
    } stage_t;

    logic [DATA_WIDTH-1:0] mux_data;
    logic                  mux_oob;
    stage_t                load_val;
    stage_t                out_s;
    logic                  sel_err_q;

    result_mux_n #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_SRC   (NUM_SRC),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_mux (
        .src    (bus.src_i),
        .sel    (bus.resultsrc_i),
        .data   (mux_data),
        .sel_oob(mux_oob)
    );

    // x0 is never written, so a pending regwrite always carries a nonzero rd.
    always_comb begin
        load_val          = '0;
        load_val.valid    = bus.valid_i;
        load_val.result   = mux_data;
        load_val.regwrite = bus.regwrite_i & bus.valid_i & (bus.rd_i != '0);
        load_val.rd       = bus.rd_i;
    end

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        stage_t d;
        stage_t q;

        if (g == 0) begin : g_first
            assign d = load_val;
        end else begin : g_next
            assign d = g_stage[g-1].q;
        end

        always_ff @(posedge clk) begin
            if (rst || bus.flush_i) begin
                q <= '0;
            end else if (!bus.stall_i) begin
                q <= d;
            end
        end
    end

    assign out_s = g_stage[NUM_STAGES-1].q;

    // Sticky until reset; only a real capture of a valid instruction can set it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err_q <= 1'b0;
        end else if (!bus.flush_i && !bus.stall_i && bus.valid_i && mux_oob) begin
            sel_err_q <= 1'b1;
        end
    end

    assign bus.valid_o    = out_s.valid;
    assign bus.result_o   = out_s.result;
    assign bus.regwrite_o = out_s.regwrite;
    assign bus.rd_o       = out_s.rd;
    assign bus.sel_err_o  = sel_err_q;
    assign bus.fwd_hit1_o = out_s.valid & out_s.regwrite & (out_s.rd == bus.rs1_i);
    assign bus.fwd_hit2_o = out_s.valid & out_s.regwrite & (out_s.rd == bus.rs2_i);

endmodule
